// File: rtl/outport_pkg.sv
// outport_pkg: shared types and width helpers for the buffered output port.
//   state_t  - output-stage FSM state (IDLE: OUT not valid, PRESENT: OUT valid)
//   ptr_w()  - FIFO pointer width for a given depth
//   cnt_w()  - FIFO occupancy width for a given depth (must represent 0..depth)
package outport_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/outport_fifo.sv
// outport_fifo: circular-buffer FIFO feeding the output register.
// Ports:
//   CLK, RST_N       clock, synchronous active-low reset (control state only)
//   push, push_data  write request / data; ignored while full
//   pop, head        read request / word at the read pointer (combinational)
//   count            registered occupancy 0..DEPTH
//   full, empty      registered flags, always consistent with count
// DEPTH must be a power of two so the pointers wrap naturally.
module outport_fifo
  import outport_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_en;
  logic              pop_en;
  logic [CNT_W-1:0]  count_nxt;

  // Flags are sampled pre-edge: a push while full is dropped even when a pop
  // frees a slot on the same edge.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_en, pop_en})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // ---- storage (no reset: contents are only meaningful below count) ----
  always_ff @(posedge CLK) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  // ---- pointers and occupancy ----
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/buffered_output_port.sv
// buffered_output_port: CPU write port with a Depth-entry FIFO and a
// registered, valid/ack handshaked output word.
// Ports:
//   CLK, RST_N  clock, synchronous active-low reset
//   DATA, Load  write data and write strobe (dropped while FULL)
//   OUT         registered output word, holds its last value after acceptance
//   OUT_VALID   OUT holds a word not yet accepted
//   OUT_ACK     consumer accepts OUT this cycle (ignored while OUT_VALID=0)
//   FULL, EMPTY, COUNT  FIFO status, excluding the output register
// Optional build macro OUTPORT_OVERFLOW_FLAG_EN adds:
//   OVERFLOW    sticky flag, set by any Load while FULL
//   OVF_CLR     clears OVERFLOW (a simultaneous set wins)
module buffered_output_port
  import outport_pkg::*;
#(
  parameter int                OutSize    = 8,
  parameter int                Depth      = 4,
  parameter logic [OutSize-1:0] ResetValue = '0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [OutSize-1:0]      DATA,
  input  logic                    Load,
  output logic [OutSize-1:0]      OUT,
  output logic                    OUT_VALID,
  input  logic                    OUT_ACK,
`ifdef OUTPORT_OVERFLOW_FLAG_EN
  output logic                    OVERFLOW,
  input  logic                    OVF_CLR,
`endif
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [cnt_w(Depth)-1:0] COUNT
);

  state_t             state, state_nxt;
  logic               pop;
  logic [OutSize-1:0] head;
  logic [OutSize-1:0] out_p1;

  outport_fifo #(
    .DATA_W (OutSize),
    .DEPTH  (Depth)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (Load),
    .push_data (DATA),
    .pop       (pop),
    .head      (head),
    .count     (COUNT),
    .full      (FULL),
    .empty     (EMPTY)
  );

  // A pop refills OUT either from idle or on the same edge the current word
  // is accepted, which sustains one word per cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY) begin
          pop       = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (OUT_ACK) begin
          if (!EMPTY) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output stage: FSM and OUT register ----
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      out_p1 <= ResetValue;
    end else begin
      state <= state_nxt;
      if (pop) out_p1 <= head;
    end
  end

  assign OUT       = out_p1;
  assign OUT_VALID = (state == PRESENT);

`ifdef OUTPORT_OVERFLOW_FLAG_EN
  always_ff @(posedge CLK) begin
    if (!RST_N)             OVERFLOW <= 1'b0;
    else if (Load && FULL)  OVERFLOW <= 1'b1;
    else if (OVF_CLR)       OVERFLOW <= 1'b0;
  end
`endif

endmodule
